// File: rtl/cy_sync_v2_0.sv
// Multi-bit input synchronizer with an enable-held output register and per-bit edge pulses.
// Define CY_SYNC_V2_0_FILTER_EN to add a per-bit persistence (glitch) filter ahead of s_out.
module cy_sync_v2_0 #(
  parameter int                     SignalWidth  = 1,
  parameter int                     SyncStages   = 2,
  parameter logic [SignalWidth-1:0] ResetValue   = '0,
  parameter int                     FilterCycles = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [SignalWidth-1:0] s_in,
  output logic [SignalWidth-1:0] s_out,
  output logic [SignalWidth-1:0] s_rise,
  output logic [SignalWidth-1:0] s_fall,
  output logic                   s_change
);

  if (SignalWidth < 1 || SignalWidth > 32) begin : g_bad_width
    $error("cy_sync_v2_0: SignalWidth must be in 1..32");
  end
  if (SyncStages < 2 || SyncStages > 4) begin : g_bad_stages
    $error("cy_sync_v2_0: SyncStages must be in 2..4");
  end
  if (FilterCycles < 1 || FilterCycles > 15) begin : g_bad_filter
    $error("cy_sync_v2_0: FilterCycles must be in 1..15");
  end

  // The chain shifts every edge, independent of enable, so a re-enabled
  // output picks up the current input rather than a stale one.
  logic [SignalWidth-1:0] chain [SyncStages];
  logic [SignalWidth-1:0] chain_out;
  logic [SignalWidth-1:0] out_next;
  logic [SignalWidth-1:0] rise_next;
  logic [SignalWidth-1:0] fall_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SyncStages; k++) begin
        chain[k] <= ResetValue;
      end
    end else begin
      chain[0] <= s_in;
      for (int k = 1; k < SyncStages; k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  assign chain_out = chain[SyncStages-1];

`ifdef CY_SYNC_V2_0_FILTER_EN
  localparam int CntWidth = ($clog2(FilterCycles + 1) < 1) ? 1 : $clog2(FilterCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(FilterCycles - 1);

  logic [CntWidth-1:0] cnt      [SignalWidth];
  logic [CntWidth-1:0] cnt_next [SignalWidth];

  // A changed chain bit must persist for FilterCycles enabled edges in a row
  // before s_out follows; any agreement or a disabled edge restarts the count.
  always_comb begin
    out_next = s_out;
    for (int i = 0; i < SignalWidth; i++) begin
      cnt_next[i] = '0;
    end
    if (enable) begin
      for (int i = 0; i < SignalWidth; i++) begin
        if (chain_out[i] == s_out[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CntLast) begin
          out_next[i] = chain_out[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < SignalWidth; i++) begin
      if (!reset_n) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_next[i];
      end
    end
  end
`else
  always_comb begin
    out_next = enable ? chain_out : s_out;
  end
`endif

  // Pulses are derived from the value about to be loaded so they appear in
  // the same cycle s_out changes; a held s_out yields no pulse.
  assign rise_next = out_next & ~s_out;
  assign fall_next = ~out_next & s_out;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_out    <= ResetValue;
      s_rise   <= '0;
      s_fall   <= '0;
      s_change <= 1'b0;
    end else begin
      s_out    <= out_next;
      s_rise   <= rise_next;
      s_fall   <= fall_next;
      s_change <= |(rise_next | fall_next);
    end
  end

endmodule

// File: tb/tb_cy_sync_v2_0.sv
// Bench for cy_sync_v2_0: two instances (2-stage and 4-stage chains) compared every
// cycle against an input-history reference model, plus directed latency/hold checks.
module tb_cy_sync_v2_0;

`ifdef CY_SYNC_V2_0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int FILT_CYC = 3;
  localparam logic [3:0] RV0 = 4'b1010;
  localparam logic [3:0] RV1 = 4'b0000;

  // clock / reset block
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] s_in;
  always #5 clk = ~clk;

  logic [3:0] out0, rise0, fall0;
  logic       chg0;
  logic [3:0] out1, rise1, fall1;
  logic       chg1;

  cy_sync_v2_0 #(.SignalWidth(4), .SyncStages(2), .ResetValue(RV0), .FilterCycles(FILT_CYC)) dut0 (
    .clock(clk), .reset_n(rst_n), .enable(en), .s_in(s_in),
    .s_out(out0), .s_rise(rise0), .s_fall(fall0), .s_change(chg0)
  );

  cy_sync_v2_0 #(.SignalWidth(4), .SyncStages(4), .ResetValue(RV1), .FilterCycles(FILT_CYC)) dut1 (
    .clock(clk), .reset_n(rst_n), .enable(en), .s_in(s_in),
    .s_out(out1), .s_rise(rise1), .s_fall(fall1), .s_change(chg1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every edge's (reset_n, s_in) is logged. The value leaving a
  // chain of depth s after an edge is the input logged s-1 edges earlier, or the
  // reset value if any reset fell inside that window.
  typedef struct packed {
    logic       rst_n;
    logic [3:0] d;
  } samp_t;
  samp_t hist[$];

  logic [3:0] m_out  [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic       m_chg  [2];
  int         m_cnt  [2][4];

  function automatic int stages_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic [3:0] rv_of(input int k);
    return (k == 0) ? RV0 : RV1;
  endfunction

  function automatic logic [3:0] chain_before(input int s, input logic [3:0] rv);
    int m;
    m = hist.size() - 2;
    if (m - s + 1 < 0) return rv;
    for (int j = m - s + 1; j <= m; j++) begin
      if (!hist[j].rst_n) return rv;
    end
    return hist[m - s + 1].d;
  endfunction

  task automatic model_edge();
    samp_t      sm;
    logic [3:0] c;
    logic [3:0] nxt;
    sm.rst_n = rst_n;
    sm.d     = s_in;
    hist.push_back(sm);
    for (int k = 0; k < 2; k++) begin
      c = chain_before(stages_of(k), rv_of(k));
      if (!rst_n) begin
        m_out[k]  = rv_of(k);
        m_rise[k] = '0;
        m_fall[k] = '0;
        m_chg[k]  = 1'b0;
        for (int b = 0; b < 4; b++) m_cnt[k][b] = 0;
      end else begin
        nxt = m_out[k];
        for (int b = 0; b < 4; b++) begin
          if (!en) begin
            m_cnt[k][b] = 0;
          end else if (!FILT) begin
            nxt[b] = c[b];
          end else if (c[b] == m_out[k][b]) begin
            m_cnt[k][b] = 0;
          end else if (m_cnt[k][b] == FILT_CYC - 1) begin
            nxt[b] = c[b];
            m_cnt[k][b] = 0;
          end else begin
            m_cnt[k][b] = m_cnt[k][b] + 1;
          end
        end
        m_rise[k] = nxt & ~m_out[k];
        m_fall[k] = ~nxt & m_out[k];
        m_chg[k]  = |(m_rise[k] | m_fall[k]);
        m_out[k]  = nxt;
      end
    end
  endtask

  // scoreboard: expected outputs of both instances compared each cycle
  task automatic check_all();
    chk("out0",  32'(out0),  32'(m_out[0]));
    chk("rise0", 32'(rise0), 32'(m_rise[0]));
    chk("fall0", 32'(fall0), 32'(m_fall[0]));
    chk("chg0",  32'(chg0),  32'(m_chg[0]));
    chk("out1",  32'(out1),  32'(m_out[1]));
    chk("rise1", 32'(rise1), 32'(m_rise[1]));
    chk("fall1", 32'(fall1), 32'(m_fall[1]));
    chk("chg1",  32'(chg1),  32'(m_chg[1]));
    chk("rise_fall_excl0", 32'(rise0 & fall0), 32'h0);
  endtask

  // driver task: apply inputs, take one edge, check 1 time unit later
  task automatic step(input logic r, input logic e, input logic [3:0] d);
    rst_n = r;
    en    = e;
    s_in  = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int lat0, lat1, en_lat;
  logic [3:0] rd;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    s_in  = 4'b0101;
    lat0   = 2 + (FILT ? FILT_CYC : 1);
    lat1   = 4 + (FILT ? FILT_CYC : 1);
    en_lat = FILT ? FILT_CYC : 1;

    // reset and latency
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b0101);
      chk("rst_out0", 32'(out0), 32'(4'b1010));
      chk("rst_pulse0", 32'({rise0, fall0, chg0}), 32'h0);
    end
    for (int e = 1; e <= lat1 + 1; e++) begin
      step(1'b1, 1'b1, 4'b0101);
      if (e == lat0 - 1) chk("rel_out0_before", 32'(out0), 32'(4'b1010));
      if (e == lat0) begin
        chk("rel_out0", 32'(out0), 32'(4'b0101));
        chk("rel_rise0", 32'(rise0), 32'(4'b0101));
        chk("rel_fall0", 32'(fall0), 32'(4'b1010));
        chk("rel_chg0", 32'(chg0), 32'h1);
      end
      if (e == lat0 + 1) chk("rel_pulse0_once", 32'({rise0, fall0, chg0}), 32'h0);
      if (e == lat1 - 1) chk("lat4_out1_before", 32'(out1), 32'(4'b0000));
      if (e == lat1) begin
        chk("lat4_out1", 32'(out1), 32'(4'b0101));
        chk("lat4_rise1", 32'(rise1), 32'(4'b0101));
      end
    end

    // 1->0 step on every bit for the deep chain
    for (int e = 1; e <= lat1 + 1; e++) begin
      step(1'b1, 1'b1, 4'b0000);
      if (e == lat1) chk("lat4_fall1", 32'(fall1), 32'(4'b0101));
    end

    // enable hold
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, {3'b000, 1'(((i / 3) % 2) == 1)});
      chk("hold_out0", 32'(out0), 32'(4'b0000));
      chk("hold_pulse0", 32'({rise0, fall0, chg0}), 32'h0);
    end
    for (int e = 1; e <= en_lat + 1; e++) begin
      step(1'b1, 1'b1, 4'b0001);
      if (e == en_lat) begin
        chk("reen_out0", 32'(out0), 32'(4'b0001));
        chk("reen_rise0", 32'(rise0), 32'(4'b0001));
      end
    end

    // glitch on bit 1, then a sustained step
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 4'b0010);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'b0010);

    // mid-operation reset one edge before the update
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'b0000);
    for (int e = 1; e < lat0 - 1; e++) step(1'b1, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 4'b0001);
    chk("midrst_out0", 32'(out0), 32'(RV0));
    chk("midrst_pulse0", 32'({rise0, fall0, chg0}), 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'b0001);

    // back-to-back toggles on bit 2
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, {1'b0, 1'(i % 2), 2'b01});

    // randomized traffic
    rd = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rd = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 4) != 0), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
